// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM states, default width and line levels for the parity serializer
package parity_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DEF_DATA_W = 4;
  localparam logic IDLE_LVL = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/parity_rr_arb.sv
// parity_rr_arb: 2-way round-robin arbiter holding the last-grant pointer
module parity_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic last;
  // pointer resets to 1 so requester 0 wins the first contended round
  assign gnt_id = &req ? ~last : req[1];
  assign gnt = ~|req ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (upd) last <= gnt_id;
endmodule

// File: rtl/parity_tx_sched.sv
// parity_tx_sched: arbitrates two nibble sources and serializes a start/data/parity/stop frame
module parity_tx_sched
  import parity_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int BIT_CYCLES = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              grant_id,
  output logic              frame_done
);
  localparam int CW  = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int BW  = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int PEN = BIT_CYCLES > 1 ? BIT_CYCLES - 2 : 0;
  state_t            state;
  logic [CW-1:0]     cyc;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg, sh_nxt, cap;
  logic [1:0]        gnt;
  logic              gid, par, hs, last_cyc, done_set;
  parity_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .upd    (hs),
    .gnt    (gnt),
    .gnt_id (gid)
  );
  assign req_ready = (rst_n && state == IDLE) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign cap       = gid ? req_data1 : req_data0;
  assign sh_nxt    = shreg >> 1;
  assign tx_busy   = state != IDLE;
  assign last_cyc  = cyc == CW'(BIT_CYCLES - 1);
  // frame_done is registered, so it is set one edge ahead of the last STOP cycle
  assign done_set  = BIT_CYCLES == 1 ? state == PARITY : (state == STOP && cyc == CW'(PEN));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tx_out     <= IDLE_LVL;
      grant_id   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_set;
      if (state == IDLE) begin
        if (hs) begin
          state    <= START;
          cyc      <= '0;
          shreg    <= cap;
          par      <= ODD_PARITY ? ~^cap : ^cap;
          grant_id <= gid;
          tx_out   <= START_LVL;
        end
      end else if (!last_cyc) begin
        cyc <= cyc + 1'b1;
      end else begin
        cyc <= '0;
        case (state)
          START: begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= shreg[0];
          end
          DATA: begin
            if (bit_idx == BW'(DATA_W - 1)) begin
              state  <= PARITY;
              tx_out <= par;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= sh_nxt;
              tx_out  <= sh_nxt[0];
            end
          end
          PARITY: begin
            state  <= STOP;
            tx_out <= STOP_LVL;
          end
          default: begin
            state  <= IDLE;
            tx_out <= IDLE_LVL;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_parity_tx_sched.sv
// tb_parity_tx_sched: directed frame checks on even- and odd-parity instances driven in lockstep
module tb_parity_tx_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_data0 = 4'h0, req_data1 = 4'h0;
  logic [1:0] req_ready, ready_o;
  logic       tx_out, tx_busy, grant_id, frame_done;
  logic       tx_o, busy_o, gid_o, done_o;
  int         total = 0, bad = 0;
  logic       ok;

  typedef struct {
    logic [1:0] v;
    logic [3:0] d0, d1;
    logic [1:0] gnt;
    logic [3:0] d;
    logic       gid;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  parity_tx_sched #(.DATA_W(4), .BIT_CYCLES(2), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .tx_out(tx_out), .tx_busy(tx_busy), .grant_id(grant_id), .frame_done(frame_done)
  );
  parity_tx_sched #(.DATA_W(4), .BIT_CYCLES(2), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(ready_o), .tx_out(tx_o), .tx_busy(busy_o), .grant_id(gid_o), .frame_done(done_o)
  );

  function automatic logic [11:0] snap();
    return {tx_out, tx_o, tx_busy, busy_o, frame_done, done_o, req_ready, ready_o, grant_id, gid_o};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic handshake(input logic [1:0] v, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] egnt, output logic found);
    req_valid = v;
    req_data0 = a;
    req_data1 = b;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (|(req_valid & req_ready)) found = 1'b1;
      else @(negedge clk);
    end
    chk("hs_found", 16'(found), 16'(1'b1));
    if (found) begin
      chk("hs_grant", 16'({req_ready, ready_o}), 16'({egnt, egnt}));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input logic [3:0] d, input logic gid, input logic chg, input logic [3:0] nd);
    logic [6:0] be, bo;
    be = {1'b1, ^d, d, 1'b0};
    bo = {1'b1, ~^d, d, 1'b0};
    for (int c = 1; c <= 14; c++) begin
      if (chg && c == 5) req_data0 = nd;
      chk($sformatf("frame_c%0d", c), 16'(snap()),
          16'({be[(c-1)/2], bo[(c-1)/2], 2'b11, {2{c == 14}}, 4'b0000, gid, gid}));
      @(negedge clk);
    end
    chk("idle_gap", 16'({tx_out, tx_o, tx_busy, busy_o, frame_done, done_o}), 16'(6'b110000));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{v: 2'b01, d0: 4'hB, d1: 4'h0, gnt: 2'b01, d: 4'hB, gid: 1'b0};
    tbl[1] = '{v: 2'b10, d0: 4'h0, d1: 4'h0, gnt: 2'b10, d: 4'h0, gid: 1'b1};
    tbl[2] = '{v: 2'b11, d0: 4'h3, d1: 4'hC, gnt: 2'b01, d: 4'h3, gid: 1'b0};
    tbl[3] = '{v: 2'b11, d0: 4'h3, d1: 4'hC, gnt: 2'b10, d: 4'hC, gid: 1'b1};
    tbl[4] = '{v: 2'b11, d0: 4'h3, d1: 4'hC, gnt: 2'b01, d: 4'h3, gid: 1'b0};
    tbl[5] = '{v: 2'b11, d0: 4'h3, d1: 4'hC, gnt: 2'b10, d: 4'hC, gid: 1'b1};
    repeat (2) @(negedge clk);
    chk("reset", 16'(snap()), 16'(12'b1100_0000_0000));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 16'(snap()), 16'(12'b1100_0000_0000));
    for (int i = 0; i < 6; i++) begin
      handshake(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].gnt, ok);
      if (ok) check_frame(tbl[i].d, tbl[i].gid, 1'b0, 4'h0);
    end
    req_valid = 2'b00;
    @(negedge clk);
    // source word changes during DATA must not reach the line
    handshake(2'b01, 4'h5, 4'h0, 2'b01, ok);
    if (ok) check_frame(4'h5, 1'b0, 1'b1, 4'hA);
    req_valid = 2'b00;
    @(negedge clk);
    // last grant is 0; a mid-frame reset must restore priority to 0 anyway
    handshake(2'b01, 4'h3, 4'hC, 2'b01, ok);
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 16'({tx_out, tx_busy}), 16'(2'b01));
    rst_n = 1'b0;
    #1;
    chk("async_reset", 16'(snap()), 16'(12'b1100_0000_0000));
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    handshake(2'b11, 4'h3, 4'hC, 2'b01, ok);
    if (ok) check_frame(4'h3, 1'b0, 1'b0, 4'h0);
    req_valid = 2'b00;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
